// File: rtl/cache_arbiter.sv
// Two-way arbiter sharing the adaptor line port between I-cache and D-cache.
// Define CACHE_ARB_ROUND_ROBIN_EN for alternating contention grants; default is D-cache priority.
module cache_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [LINE_W-1:0] mem_wdata,
    input  logic [LINE_W-1:0] mem_rdata,
    input  logic              mem_resp,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

    state_t state, state_next;
    logic   grant_d, grant_d_next;
    logic   op_write, op_write_next;
    logic   req_i, req_d, pick_d, serving;

    assign req_i = icache_read;
    assign req_d = dcache_read | dcache_write;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
    logic last_d;

    // On contention, hand the grant to whoever lost the previous contended round.
    assign pick_d = req_d & (~req_i | ~last_d);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_d <= 1'b0;
        end else if (state == IDLE && req_i && req_d) begin
            last_d <= pick_d;
        end
    end
`else
    assign pick_d = req_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            grant_d  <= 1'b0;
            op_write <= 1'b0;
        end else begin
            state    <= state_next;
            grant_d  <= grant_d_next;
            op_write <= op_write_next;
        end
    end

    always_comb begin
        state_next    = state;
        grant_d_next  = grant_d;
        op_write_next = op_write;
        case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    state_next    = pick_d ? SERVE_D : SERVE_I;
                    grant_d_next  = pick_d;
                    op_write_next = pick_d & dcache_write;
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) state_next = RELEASE;
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign serving      = (state == SERVE_I) || (state == SERVE_D);
    assign mem_read     = serving & ~op_write;
    assign mem_write    = serving & op_write;
    assign mem_address  = grant_d ? dcache_address : icache_address;
    assign mem_wdata    = (grant_d && op_write) ? dcache_wdata : '0;
    assign busy         = (state != IDLE);

    // A requester that abandoned its request gets no completion pulse.
    assign icache_resp  = (state == SERVE_I) & mem_resp & icache_read;
    assign dcache_resp  = (state == SERVE_D) & mem_resp & req_d;
    assign icache_rdata = mem_rdata;
    assign dcache_rdata = mem_rdata;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a transaction-level reference model checked every cycle.
module tb_cache_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    logic              clk;
    logic              reset_n;
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic [LINE_W-1:0] mem_rdata;
    logic              mem_resp;
    logic              busy;

    int vectors = 0;
    int errors  = 0;

    logic [LINE_W-1:0] pat_a, pat_w, pat_b, pat_w2;
    logic [ADDR_W-1:0] first_addr, second_addr;

    cache_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset_n(reset_n),
        .icache_read(icache_read), .icache_address(icache_address),
        .icache_rdata(icache_rdata), .icache_resp(icache_resp),
        .dcache_read(dcache_read), .dcache_write(dcache_write),
        .dcache_address(dcache_address), .dcache_wdata(dcache_wdata),
        .dcache_rdata(dcache_rdata), .dcache_resp(dcache_resp),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_b(input string nm, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_a(input string nm, input logic [ADDR_W-1:0] act, input logic [ADDR_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_l(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the adaptor, which op, plus the one-cycle cool-down.
    int m_owner;      // 0 nobody, 1 I-cache, 2 D-cache
    bit m_release;
    bit m_src_d;
    bit m_write;
    bit m_last_d;

    always @(posedge clk or negedge reset_n) begin
        bit want_d, win_d;
        if (!reset_n) begin
            m_owner   <= 0;
            m_release <= 1'b0;
            m_src_d   <= 1'b0;
            m_write   <= 1'b0;
            m_last_d  <= 1'b0;
        end else if (m_owner != 0) begin
            if (mem_resp) begin
                m_owner   <= 0;
                m_release <= 1'b1;
            end
        end else if (m_release) begin
            m_release <= 1'b0;
        end else begin
            want_d = dcache_read || dcache_write;
            if (icache_read || want_d) begin
                if (icache_read && want_d) begin
                    win_d = RR_EN ? !m_last_d : 1'b1;
                    m_last_d <= win_d;
                end else begin
                    win_d = want_d;
                end
                m_owner <= win_d ? 2 : 1;
                m_src_d <= win_d;
                m_write <= win_d && dcache_write;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check_b("cmp_mem_read", mem_read, (m_owner != 0) && !m_write);
            check_b("cmp_mem_write", mem_write, (m_owner != 0) && m_write);
            check_a("cmp_mem_address", mem_address, m_src_d ? dcache_address : icache_address);
            check_l("cmp_mem_wdata", mem_wdata, (m_src_d && m_write) ? dcache_wdata : '0);
            check_b("cmp_icache_resp", icache_resp, (m_owner == 1) && mem_resp && icache_read);
            check_b("cmp_dcache_resp", dcache_resp,
                    (m_owner == 2) && mem_resp && (dcache_read || dcache_write));
            check_l("cmp_icache_rdata", icache_rdata, mem_rdata);
            check_l("cmp_dcache_rdata", dcache_rdata, mem_rdata);
            check_b("cmp_busy", busy, (m_owner != 0) || m_release);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in the first SERVE cycle; raises mem_resp in SERVE cycle 'lat'.
    task automatic respond(input int lat, input logic [LINE_W-1:0] data);
        for (int i = 1; i < lat; i++) tick();
        mem_resp  = 1'b1;
        mem_rdata = data;
        #1;
    endtask

    // Leaves the response cycle, checks the RELEASE gap, lands in IDLE.
    task automatic finish_txn(input bit drop_i, input bit drop_d);
        tick();
        mem_resp = 1'b0;
        if (drop_i) icache_read = 1'b0;
        if (drop_d) begin
            dcache_read  = 1'b0;
            dcache_write = 1'b0;
        end
        #1;
        check_b("release_busy", busy, 1'b1);
        check_b("release_no_read", mem_read, 1'b0);
        check_b("release_no_write", mem_write, 1'b0);
        tick();
    endtask

    initial begin
        pat_a  = {32{8'hA5}};
        pat_w  = {8{32'h12345678}};
        pat_b  = {16{16'hBEEF}};
        pat_w2 = {8{32'hCAFE_F00D}};
        reset_n = 1'b0;
        icache_read = 1'b0; icache_address = '0;
        dcache_read = 1'b0; dcache_write = 1'b0; dcache_address = '0; dcache_wdata = '0;
        mem_rdata = '0; mem_resp = 1'b0;
        #2;
        check_b("rst_mem_read", mem_read, 1'b0);
        check_b("rst_mem_write", mem_write, 1'b0);
        check_b("rst_icache_resp", icache_resp, 1'b0);
        check_b("rst_dcache_resp", dcache_resp, 1'b0);
        check_b("rst_busy", busy, 1'b0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        // I-cache read alone, five-cycle adaptor latency
        icache_read = 1'b1; icache_address = 32'h0000_1000;
        #1;
        check_b("t1_idle_no_read", mem_read, 1'b0);
        tick(); #1;
        check_b("t1_read_n1", mem_read, 1'b1);
        check_a("t1_addr", mem_address, 32'h0000_1000);
        respond(5, pat_a);
        check_b("t1_iresp", icache_resp, 1'b1);
        check_l("t1_irdata", icache_rdata, pat_a);
        check_b("t1_dresp", dcache_resp, 1'b0);
        finish_txn(1'b1, 1'b0);

        // stray adaptor response while idle
        mem_resp = 1'b1;
        #1;
        check_b("stray_iresp", icache_resp, 1'b0);
        check_b("stray_dresp", dcache_resp, 1'b0);
        tick();
        mem_resp = 1'b0;

        // D-cache write alone
        dcache_write = 1'b1; dcache_address = 32'h0000_2040; dcache_wdata = pat_w;
        tick(); #1;
        check_b("t2_write", mem_write, 1'b1);
        check_b("t2_no_read", mem_read, 1'b0);
        check_a("t2_addr", mem_address, 32'h0000_2040);
        check_l("t2_wdata", mem_wdata, pat_w);
        respond(3, '0);
        check_b("t2_dresp", dcache_resp, 1'b1);
        check_b("t2_iresp", icache_resp, 1'b0);
        finish_txn(1'b0, 1'b1);

        // first contention: D wins under both policies
        icache_read = 1'b1; icache_address = 32'h0000_0100;
        dcache_read = 1'b1; dcache_address = 32'h0000_0200;
        tick(); #1;
        check_a("t3_first_addr", mem_address, 32'h0000_0200);
        respond(2, pat_b);
        check_b("t3_first_dresp", dcache_resp, 1'b1);
        check_b("t3_first_iresp", icache_resp, 1'b0);
        finish_txn(1'b0, 1'b1);
        tick(); #1;
        check_a("t3_second_addr", mem_address, 32'h0000_0100);
        respond(2, pat_a);
        check_b("t3_second_iresp", icache_resp, 1'b1);
        finish_txn(1'b1, 1'b0);

        // second contention: policy decides
        icache_read = 1'b1; dcache_read = 1'b1;
        first_addr  = RR_EN ? 32'h0000_0100 : 32'h0000_0200;
        second_addr = RR_EN ? 32'h0000_0200 : 32'h0000_0100;
        tick(); #1;
        check_a("t3b_first_addr", mem_address, first_addr);
        respond(2, pat_b);
        check_b("t3b_first_iresp", icache_resp, RR_EN);
        check_b("t3b_first_dresp", dcache_resp, !RR_EN);
        finish_txn(RR_EN, !RR_EN);
        tick(); #1;
        check_a("t3b_second_addr", mem_address, second_addr);
        respond(1, pat_a);
        check_b("t3b_second_iresp", icache_resp, !RR_EN);
        check_b("t3b_second_dresp", dcache_resp, RR_EN);
        finish_txn(1'b1, 1'b1);

        // read and write together count as write
        dcache_read = 1'b1; dcache_write = 1'b1;
        dcache_address = 32'h0000_0300; dcache_wdata = pat_w2;
        tick(); #1;
        check_b("t4_write", mem_write, 1'b1);
        check_b("t4_no_read", mem_read, 1'b0);
        check_l("t4_wdata", mem_wdata, pat_w2);
        respond(1, '0);
        check_b("t4_dresp", dcache_resp, 1'b1);
        finish_txn(1'b0, 1'b1);

        // D request abandoned mid-service
        dcache_read = 1'b1; dcache_address = 32'h0000_0400;
        tick(); #1;
        check_b("t5_read_c1", mem_read, 1'b1);
        tick();
        dcache_read = 1'b0;
        #1;
        check_b("t5_read_held", mem_read, 1'b1);
        tick();
        tick();
        mem_resp = 1'b1; mem_rdata = pat_b;
        #1;
        check_b("t5_read_at_resp", mem_read, 1'b1);
        check_b("t5_dresp_suppressed", dcache_resp, 1'b0);
        finish_txn(1'b0, 1'b0);
        icache_read = 1'b1; icache_address = 32'h0000_0500;
        tick(); #1;
        check_b("t5_i_read", mem_read, 1'b1);
        check_a("t5_i_addr", mem_address, 32'h0000_0500);
        respond(2, pat_a);
        check_b("t5_i_resp", icache_resp, 1'b1);
        finish_txn(1'b1, 1'b0);

        // asynchronous reset in the middle of SERVE_I
        icache_read = 1'b1; icache_address = 32'h0000_0600;
        tick();
        tick();
        mem_resp = 1'b1;
        #1;
        check_b("t6_iresp_before_rst", icache_resp, 1'b1);
        reset_n = 1'b0;
        #1;
        check_b("t6_rst_read", mem_read, 1'b0);
        check_b("t6_rst_iresp", icache_resp, 1'b0);
        check_b("t6_rst_busy", busy, 1'b0);
        mem_resp = 1'b0;
        tick();
        reset_n = 1'b1;
        #1;
        check_b("t6_idle_read", mem_read, 1'b0);
        check_b("t6_idle_busy", busy, 1'b0);
        tick(); #1;
        check_b("t6_regrant_read", mem_read, 1'b1);
        check_a("t6_regrant_addr", mem_address, 32'h0000_0600);
        respond(2, pat_b);
        check_b("t6_iresp", icache_resp, 1'b1);
        check_l("t6_irdata", icache_rdata, pat_b);
        finish_txn(1'b1, 1'b0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/cache_arbiter.md
Name: cache_arbiter

Overview:
Shares the single LLC-side line port of the cacheline adaptor between the I-cache (read-only) and the D-cache (read/write).
- Accepts one 256-bit line transaction at a time.
- Holds the granted requester on the adaptor until the adaptor responds, then routes the response back to that requester.
- Sits between the split L1 caches and the cacheline adaptor.

Parameters:
LINE_W, 256, line width in bits; must equal the adaptor line width
ADDR_W, 32, address width in bits

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  reset, asynchronous, active-low
icache_read  in  1  I-cache line read request, level, held until icache_resp
icache_address  in  ADDR_W  I-cache line address
icache_rdata  out  LINE_W  read line to I-cache
icache_resp  out  1  one-cycle completion pulse to I-cache
dcache_read  in  1  D-cache line read request, level
dcache_write  in  1  D-cache line write request, level
dcache_address  in  ADDR_W  D-cache line address
dcache_wdata  in  LINE_W  D-cache write line
dcache_rdata  out  LINE_W  read line to D-cache
dcache_resp  out  1  one-cycle completion pulse to D-cache
mem_read  out  1  read request to adaptor
mem_write  out  1  write request to adaptor
mem_address  out  ADDR_W  address to adaptor
mem_wdata  out  LINE_W  write line to adaptor
mem_rdata  in  LINE_W  read line from adaptor
mem_resp  in  1  one-cycle completion pulse from adaptor
busy  out  1  high in SERVE_I, SERVE_D and RELEASE

Behaviour:
- Reset: asynchronous, active-low.
  - state=IDLE, grant register=I, last-winner=I.
  - All resp, mem_read and mem_write outputs are 0; busy=0.
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE:
  - Evaluates requests combinationally each cycle.
  - icache_read only -> SERVE_I.
  - dcache_read or dcache_write only -> SERVE_D.
  - Both I and D requesting: arbitration policy decides (see Optional Feature).
  - Operation latched in this cycle: D write when dcache_write=1 (write wins if dcache_read and dcache_write are both high), else read.
  - mem_read and mem_write are 0 in IDLE.
- SERVE_x:
  - mem_read or mem_write held at 1 (per the latched op) every cycle until mem_resp.
  - mem_address and mem_wdata are muxed from the grant register, never from the other requester.
  - mem_wdata drives dcache_wdata for D writes, else 0.
  - On mem_resp=1: the granted requester's resp=1 in the same cycle (zero-latency passthrough); next state RELEASE.
- RELEASE:
  - One cycle with mem_read=mem_write=0, so the adaptor returns to its start state without seeing a stale request.
  - Always -> IDLE.
- Request latency: request seen in IDLE at cycle N -> mem_read/mem_write asserted at N+1.
- Minimum turnaround between back-to-back grants: 2 cycles (RELEASE, IDLE).
- mem_address outside SERVE: driven from the grant register (last granted address source); don't-care for the adaptor.
- icache_rdata and dcache_rdata both equal mem_rdata, unconditionally (broadcast). Each is valid only with its own resp.
- Requester drops its request mid-service (protocol violation):
  - Downstream request is still held until mem_resp; the adaptor cannot be aborted.
  - The resp pulse to that requester is suppressed when its request is low in the mem_resp cycle.
- mem_resp outside SERVE: ignored, no resp generated.
- Reset during SERVE: immediate return to IDLE with all outputs 0. The adaptor is reset by the same reset_n.
- resp outputs are never high simultaneously, and never high for more than one cycle per transaction.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined:
  - Simultaneous I and D requests in IDLE grant the requester that did NOT win the last contended grant.
  - last-winner updates only on contended grants; resets to I, so the first contended grant goes to D.
- Undefined: fixed priority, D-cache always wins contention; last-winner register not implemented.

Test Plan:
- I read alone, addr 0x0000_1000, adaptor responds after 5 cycles with 256'hA5... -> mem_read high 5 cycles; icache_resp 1 cycle with icache_rdata=256'hA5...; dcache_resp=0; one RELEASE cycle with mem_read=0.
- D write alone, addr 0x0000_2040, wdata 256'h1234... -> mem_write=1, mem_wdata=256'h1234..., mem_address=0x0000_2040 until mem_resp; dcache_resp pulse.
- I read 0x100 and D read 0x200 in same cycle, held through two transactions:
  - Fixed priority: D served first (mem_address=0x200), then I (0x100).
  - Round robin: first contention D, second contention I.
- dcache_read=dcache_write=1 together -> treated as write: mem_write=1, mem_read=0.
- D request dropped two cycles into SERVE_D -> mem_read held until mem_resp; dcache_resp stays 0; next I request served normally.
- reset_n low mid SERVE_I -> mem_read and icache_resp go 0 immediately (asynchronous); after release, state IDLE; new I request granted at N+1.
